// File: rtl/kron_stream_seq_if.sv
// Output stream bundle of the sequential Kronecker engine: one product
// element per valid/ready handshake with its row/col coordinates.
// Ports: out_valid/out_data/out_row/out_col/out_last driven by the producer
// (master), out_ready driven by the consumer (slave).
// rw/cw must equal the producer's max(1,$clog2(m*p)) / max(1,$clog2(n*q)).
interface kron_stream_seq_if #(
  parameter int word_size = 32,
  parameter int rw        = 2,
  parameter int cw        = 2
);
  logic                 out_valid;
  logic                 out_ready;
  logic [word_size-1:0] out_data;
  logic [rw-1:0]        out_row;
  logic [cw-1:0]        out_col;
  logic                 out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/kron_stream_seq.sv
// Sequential Kronecker product A (m x n) (x) B (p x q) through one shared multiplier.
// Latency: element (0,0) valid the cycle after start; one element per cycle after.
// Backpressure: all stream outputs hold while out_valid && !out_ready.
// Ports: clk, rst_n (async active-low), start, A/B (MSB-first row-major packed),
// busy, done (1-cycle pulse after last handshake), out_if (stream, master side).
module kron_stream_seq #(
  parameter int word_size     = 32,
  parameter int Amatrixrownum = 2,
  parameter int Amatrixcolnum = 2,
  parameter int Bmatrixrownum = 2,
  parameter int Bmatrixcolnum = 2
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                start,
  input  logic [Amatrixrownum*Amatrixcolnum*word_size-1:0]    A,
  input  logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0]    B,
  output logic                                                busy,
  output logic                                                done,
  kron_stream_seq_if.master                                   out_if
);
  localparam int m    = Amatrixrownum;
  localparam int n    = Amatrixcolnum;
  localparam int p    = Bmatrixrownum;
  localparam int q    = Bmatrixcolnum;
  localparam int rows = m * p;
  localparam int cols = n * q;
  localparam int rw   = (rows > 1) ? $clog2(rows) : 1;
  localparam int cw   = (cols > 1) ? $clog2(cols) : 1;
  localparam int xw   = (m > 1) ? $clog2(m) : 1;
  localparam int yw   = (n > 1) ? $clog2(n) : 1;
  localparam int zw   = (p > 1) ? $clog2(p) : 1;
  localparam int ww   = (q > 1) ? $clog2(q) : 1;

  localparam logic [rw-1:0] row_max = rw'(rows - 1);
  localparam logic [cw-1:0] col_max = cw'(cols - 1);
  localparam logic [yw-1:0] y_max   = yw'(n - 1);
  localparam logic [zw-1:0] z_max   = zw'(p - 1);
  localparam logic [ww-1:0] w_max   = ww'(q - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [m*n*word_size-1:0] a_q;
  logic [p*q*word_size-1:0] b_q;
  logic [word_size-1:0]     a_el [m][n];
  logic [word_size-1:0]     b_el [p][q];

  // Product row = x*p+z, column = y*q+w; the four sub-indices are kept as
  // counters beside row/col so no divider is needed to find the operands.
  logic [xw-1:0] x_q, x_d;
  logic [yw-1:0] y_q, y_d;
  logic [zw-1:0] z_q, z_d;
  logic [ww-1:0] w_q, w_d;
  logic [rw-1:0] row_q, row_d;
  logic [cw-1:0] col_q, col_d;

  logic [word_size-1:0] data_q, mul_a, mul_b, prod;
  logic                 valid_q, busy_q, done_q;
  logic                 hs, is_last, w_wrap, y_wrap, z_wrap, col_wrap;
  logic                 load_first, advance, finish;

  for (genvar r = 0; r < m; r++) begin : g_a_row
    for (genvar c = 0; c < n; c++) begin : g_a_col
      assign a_el[r][c] = a_q[(m*n-(r*n+c))*word_size-1 -: word_size];
    end
  end
  for (genvar r = 0; r < p; r++) begin : g_b_row
    for (genvar c = 0; c < q; c++) begin : g_b_col
      assign b_el[r][c] = b_q[(p*q-(r*q+c))*word_size-1 -: word_size];
    end
  end

  assign hs       = valid_q && out_if.out_ready;
  assign is_last  = (row_q == row_max) && (col_q == col_max);
  assign w_wrap   = (w_q == w_max);
  assign y_wrap   = (y_q == y_max);
  assign z_wrap   = (z_q == z_max);
  assign col_wrap = (col_q == col_max);

  // Coordinates of the element that follows the one currently presented.
  always_comb begin
    w_d   = w_wrap ? '0 : w_q + 1'b1;
    y_d   = w_wrap ? (y_wrap ? '0 : y_q + 1'b1) : y_q;
    col_d = col_wrap ? '0 : col_q + 1'b1;
    z_d   = col_wrap ? (z_wrap ? '0 : z_q + 1'b1) : z_q;
    x_d   = (col_wrap && z_wrap) ? x_q + 1'b1 : x_q;
    row_d = col_wrap ? row_q + 1'b1 : row_q;
  end

  // Shared multiplier: in IDLE it sees element (0,0) straight from the inputs
  // so the first product lands on the same edge the operands are captured.
  always_comb begin
    mul_a = a_el[x_d][y_d];
    mul_b = b_el[z_d][w_d];
    if (state_q == IDLE) begin
      mul_a = A[m*n*word_size-1 -: word_size];
      mul_b = B[p*q*word_size-1 -: word_size];
    end
    prod = mul_a * mul_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_first = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_first = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          if (is_last) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      w_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_first) begin
        a_q     <= A;
        b_q     <= B;
        x_q     <= '0;
        y_q     <= '0;
        z_q     <= '0;
        w_q     <= '0;
        row_q   <= '0;
        col_q   <= '0;
        data_q  <= prod;
        valid_q <= 1'b1;
        busy_q  <= 1'b1;
      end else if (advance) begin
        x_q    <= x_d;
        y_q    <= y_d;
        z_q    <= z_d;
        w_q    <= w_d;
        row_q  <= row_d;
        col_q  <= col_d;
        data_q <= prod;
      end else if (finish) begin
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_row   = row_q;
  assign out_if.out_col   = col_q;
  // Gated with valid so a 1x1 product does not report last out of reset.
  assign out_if.out_last  = valid_q && is_last;
endmodule

// File: tb/tb_kron_stream_seq.sv
module tb_kron_stream_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 2x2 (x) 2x2, 32-bit
  logic         s0;
  logic [127:0] a0, b0;
  logic         busy0, done0;
  kron_stream_seq_if #(.word_size(32), .rw(2), .cw(2)) if0();
  kron_stream_seq #(.word_size(32), .Amatrixrownum(2), .Amatrixcolnum(2),
                    .Bmatrixrownum(2), .Bmatrixcolnum(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(s0), .A(a0), .B(b0),
    .busy(busy0), .done(done0), .out_if(if0));

  // 2x2 (x) 2x2, 8-bit
  logic        s8;
  logic [31:0] a8, b8;
  logic        busy8, done8;
  kron_stream_seq_if #(.word_size(8), .rw(2), .cw(2)) if8();
  kron_stream_seq #(.word_size(8), .Amatrixrownum(2), .Amatrixcolnum(2),
                    .Bmatrixrownum(2), .Bmatrixcolnum(2)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .out_if(if8));

  // 1x3 (x) 2x1, 32-bit
  logic        s1;
  logic [95:0] a1;
  logic [63:0] b1;
  logic        busy1, done1;
  kron_stream_seq_if #(.word_size(32), .rw(1), .cw(2)) if1();
  kron_stream_seq #(.word_size(32), .Amatrixrownum(1), .Amatrixcolnum(3),
                    .Bmatrixrownum(2), .Bmatrixcolnum(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .out_if(if1));

  int unsigned exp0 [16] = '{0, 5, 0, 10, 6, 7, 12, 14, 0, 15, 0, 20, 18, 21, 24, 28};
  int unsigned bv   [4]  = '{0, 5, 6, 7};
  int unsigned exp1 [6]  = '{4, 8, 12, 5, 10, 15};

  localparam logic [127:0] A_ORIG = {32'd1, 32'd2, 32'd3, 32'd4};
  localparam logic [127:0] B_ORIG = {32'd0, 32'd5, 32'd6, 32'd7};

  task automatic test_reset;
    s0 = 0; s8 = 0; s1 = 0;
    a0 = A_ORIG; b0 = B_ORIG; a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    if0.out_ready = 1'b1; if8.out_ready = 1'b1; if1.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy0, done0, if0.out_valid, if0.out_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/valid/last=%b required 0000",
               {busy0, done0, if0.out_valid, if0.out_last});
    end
    checks++;
    if (if0.out_data !== 32'd0 || if0.out_row !== 2'd0 || if0.out_col !== 2'd0) begin
      errors++;
      $display("FAIL reset_data: data=%0d row=%0d col=%0d required 0 0 0",
               if0.out_data, if0.out_row, if0.out_col);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || if0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b valid=%b required 0 0", busy0, if0.out_valid);
    end
  endtask

  task automatic test_basic;
    int k = 0;
    int cyc = 0;
    a0 = A_ORIG; b0 = B_ORIG; if0.out_ready = 1'b1;
    s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    checks++;
    if (if0.out_valid !== 1'b1 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: valid=%b busy=%b required 1 1", if0.out_valid, busy0);
    end
    while (k < 16 && cyc < 64) begin
      if (if0.out_valid) begin
        checks++;
        if (if0.out_data !== exp0[k] || if0.out_row !== 2'(k / 4) ||
            if0.out_col !== 2'(k % 4) || if0.out_last !== (k == 15)) begin
          errors++;
          $display("FAIL basic_elem%0d: data=%0d row=%0d col=%0d last=%b required %0d %0d %0d %b",
                   k, if0.out_data, if0.out_row, if0.out_col, if0.out_last,
                   exp0[k], k / 4, k % 4, (k == 15));
        end
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (k != 16 || cyc != 16) begin
      errors++;
      $display("FAIL basic_rate: elements=%0d cycles=%0d required 16 16", k, cyc);
    end
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || if0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b valid=%b required 1 0 0", done0, busy0, if0.out_valid);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b required 0", done0);
    end
  endtask

  task automatic test_backpressure;
    int k = 0;
    int cyc = 0;
    int stalls = 0;
    bit stalled = 0;
    logic [31:0] pd;
    logic [1:0]  pr, pc;
    a0 = A_ORIG; b0 = B_ORIG; if0.out_ready = 1'b1;
    s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    while (k < 16 && cyc < 200) begin
      if (stalled) begin
        checks++;
        if (if0.out_data !== pd || if0.out_row !== pr || if0.out_col !== pc || if0.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_hold: data=%0d row=%0d col=%0d valid=%b required %0d %0d %0d 1",
                   if0.out_data, if0.out_row, if0.out_col, if0.out_valid, pd, pr, pc);
        end
      end
      if0.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      stalled = 0;
      if (if0.out_valid) begin
        if (if0.out_ready) begin
          checks++;
          if (if0.out_data !== exp0[k] || if0.out_row !== 2'(k / 4) || if0.out_col !== 2'(k % 4)) begin
            errors++;
            $display("FAIL bp_elem%0d: data=%0d row=%0d col=%0d required %0d %0d %0d",
                     k, if0.out_data, if0.out_row, if0.out_col, exp0[k], k / 4, k % 4);
          end
          k++;
        end else begin
          pd = if0.out_data; pr = if0.out_row; pc = if0.out_col;
          stalled = 1; stalls++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if0.out_ready = 1'b1;
    checks++;
    if (k != 16 || cyc != 32 || stalls != 16) begin
      errors++;
      $display("FAIL bp_count: elements=%0d cycles=%0d stalls=%0d required 16 32 16", k, cyc, stalls);
    end
    checks++;
    if (done0 !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: done=%b required 1", done0);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int k = 0;
    int cyc = 0;
    int unsigned e;
    a0 = A_ORIG; b0 = B_ORIG; if0.out_ready = 1'b1;
    s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    while (k < 16 && cyc < 64) begin
      if (k == 2) begin a0 = {4{32'd9}}; s0 = 1'b1; end
      if (k == 4) s0 = 1'b0;
      if (if0.out_valid) begin
        checks++;
        if (if0.out_data !== exp0[k]) begin
          errors++;
          $display("FAIL iso_elem%0d: data=%0d required %0d", k, if0.out_data, exp0[k]);
        end
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done0 !== 1'b1 || k != 16) begin
      errors++;
      $display("FAIL iso_done: done=%b elements=%0d required 1 16", done0, k);
    end
    // start in the done cycle: one bubble between jobs
    s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    checks++;
    if (if0.out_valid !== 1'b1 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: valid=%b busy=%b required 1 1", if0.out_valid, busy0);
    end
    k = 0; cyc = 0;
    while (k < 16 && cyc < 64) begin
      if (if0.out_valid) begin
        e = 9 * bv[((k / 4) % 2) * 2 + ((k % 4) % 2)];
        checks++;
        if (if0.out_data !== e) begin
          errors++;
          $display("FAIL b2b_elem%0d: data=%0d required %0d", k, if0.out_data, e);
        end
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done0 !== 1'b1 || k != 16) begin
      errors++;
      $display("FAIL b2b_done: done=%b elements=%0d required 1 16", done0, k);
    end
    a0 = A_ORIG;
    @(negedge clk);
  endtask

  task automatic test_truncation;
    for (int pass = 0; pass < 2; pass++) begin
      int k = 0;
      int cyc = 0;
      logic [7:0] e;
      a8 = (pass == 0) ? {4{8'd16}} : {4{8'd15}};
      b8 = (pass == 0) ? {4{8'd16}} : {4{8'd17}};
      e  = (pass == 0) ? 8'd0 : 8'd255;
      s8 = 1'b1;
      @(negedge clk);
      s8 = 1'b0;
      while (k < 16 && cyc < 64) begin
        if (if8.out_valid) begin
          checks++;
          if (if8.out_data !== e) begin
            errors++;
            $display("FAIL trunc%0d_elem%0d: data=%0d required %0d", pass, k, if8.out_data, e);
          end
          k++;
        end
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (done8 !== 1'b1 || k != 16) begin
        errors++;
        $display("FAIL trunc%0d_done: done=%b elements=%0d required 1 16", pass, done8, k);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_nonsquare;
    int k = 0;
    int cyc = 0;
    a1 = {32'd1, 32'd2, 32'd3};
    b1 = {32'd4, 32'd5};
    s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    while (k < 6 && cyc < 32) begin
      if (if1.out_valid) begin
        checks++;
        if (if1.out_data !== exp1[k] || if1.out_row !== 1'(k / 3) ||
            if1.out_col !== 2'(k % 3) || if1.out_last !== (k == 5)) begin
          errors++;
          $display("FAIL ns_elem%0d: data=%0d row=%0d col=%0d last=%b required %0d %0d %0d %b",
                   k, if1.out_data, if1.out_row, if1.out_col, if1.out_last,
                   exp1[k], k / 3, k % 3, (k == 5));
        end
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done1 !== 1'b1 || k != 6 || cyc != 6) begin
      errors++;
      $display("FAIL ns_done: done=%b elements=%0d cycles=%0d required 1 6 6", done1, k, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    int k = 0;
    int cyc = 0;
    a0 = A_ORIG; b0 = B_ORIG; if0.out_ready = 1'b1;
    s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    while (k < 5 && cyc < 32) begin
      if (if0.out_valid) k++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (if0.out_data !== 32'd7 || if0.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: data=%0d valid=%b required 7 1", if0.out_data, if0.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, done0, if0.out_valid, if0.out_last} !== 4'b0000 ||
        if0.out_data !== 32'd0 || if0.out_row !== 2'd0 || if0.out_col !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: busy/done/valid/last=%b data=%0d row=%0d col=%0d required 0000 0 0 0",
               {busy0, done0, if0.out_valid, if0.out_last}, if0.out_data, if0.out_row, if0.out_col);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || if0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_done: done=%b valid=%b required 0 0", done0, if0.out_valid);
    end
    s0 = 1'b1;
    @(negedge clk);
    s0 = 1'b0;
    k = 0; cyc = 0;
    while (k < 16 && cyc < 64) begin
      if (if0.out_valid) begin
        if (k < 3) begin
          checks++;
          if (if0.out_data !== exp0[k] || if0.out_row !== 2'd0 || if0.out_col !== 2'(k)) begin
            errors++;
            $display("FAIL restart_elem%0d: data=%0d row=%0d col=%0d required %0d 0 %0d",
                     k, if0.out_data, if0.out_row, if0.out_col, exp0[k], k);
          end
        end
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done0 !== 1'b1 || k != 16) begin
      errors++;
      $display("FAIL restart_done: done=%b elements=%0d required 1 16", done0, k);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_while_busy();
    test_truncation();
    test_nonsquare();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
